// File: rtl/wd279x_pkg.sv
// Shared types and constants for the WD279x Force Interrupt controller.
package wd279x_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ABORT_WAIT = 2'd1,
    ST_ARMED      = 2'd2
  } fi_state_t;

  localparam logic [3:0] CMD_FORCE_INT = 4'hD;

  localparam int FI_RDY_RISE = 0;
  localparam int FI_RDY_FALL = 1;
  localparam int FI_INDEX    = 2;
  localparam int FI_IMM      = 3;

  localparam int STS_NOT_READY = 7;
  localparam int STS_WPROT     = 6;
  localparam int STS_HLD       = 5;
  localparam int STS_TRK00     = 2;
  localparam int STS_INDEX     = 1;

  typedef struct packed {
    logic readyn;
    logic indexn;
    logic wprotn;
    logic trk00n;
  } drv_sig_t;

  function automatic logic [7:0] type1_status(input drv_sig_t s, input logic hld);
    logic [7:0] st;
    st                = 8'h00;
    st[STS_NOT_READY] = s.readyn;
    st[STS_WPROT]     = ~s.wprotn;
    st[STS_HLD]       = hld;
    st[STS_TRK00]     = ~s.trk00n;
    st[STS_INDEX]     = ~s.indexn;
    return st;
  endfunction

endpackage

// File: rtl/wd279x_drive_sync.sv
// Multi-stage synchroniser for one drive's asynchronous, active-low status lines.
module wd279x_drive_sync
  import wd279x_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  drv_sig_t raw_in,
  output drv_sig_t sync_out
);

  drv_sig_t sync_q [SYNC_STAGES];
  drv_sig_t sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = raw_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Reset to all-ones so every line looks inactive until real samples arrive.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SYNC_STAGES; i++) begin
      if (reset) sync_q[i] <= '1;
      else       sync_q[i] <= sync_d[i];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/wd279x_force_intr_ctrl.sv
// WD279x Type IV (Force Interrupt) handler: sequencer abort handshake,
// per-drive READY/INDEX edge conditions, INTRQ generation and Type I status.
//
// state         | meaning
// ST_IDLE       | no armed conditions; fi_active may still be held for status
// ST_ABORT_WAIT | abort_req raised, waiting for abort_done or timeout
// ST_ARMED      | watching READY/INDEX edges of the latched drive
module wd279x_force_intr_ctrl
  import wd279x_pkg::*;
#(
  parameter int DRIVES        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int INDEX_DIV     = 1,
  parameter int ABORT_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      command_start,
  input  logic [7:0]                command,
  input  logic [$clog2(DRIVES)-1:0] drive_sel,
  input  logic                      busy_in,
  output logic                      abort_req,
  input  logic                      abort_done,
  input  logic [DRIVES-1:0]         INDEXn,
  input  logic [DRIVES-1:0]         READYn,
  input  logic [DRIVES-1:0]         WPROTn,
  input  logic [DRIVES-1:0]         TRK00n,
  input  logic                      HLD,
  output logic                      INTRQ,
  input  logic                      INTRQ_ACK,
  output logic                      interrupt,
  output logic                      armed,
  output logic [7:0]                status
);

  localparam int DW = $clog2(DRIVES);
  localparam int TW = $clog2(ABORT_TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(ABORT_TIMEOUT - 1);
  localparam logic [7:0]    IDX_LAST = 8'(INDEX_DIV - 1);

  drv_sig_t sync_s [DRIVES];

  for (genvar g = 0; g < DRIVES; g++) begin : g_sync
    wd279x_drive_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset   (reset),
      .raw_in  ({READYn[g], INDEXn[g], WPROTn[g], TRK00n[g]}),
      .sync_out(sync_s[g])
    );
  end

  fi_state_t     state_q, state_d;
  logic [3:0]    cond_q, cond_d;
  logic [DW-1:0] drv_q, drv_d;
  logic          fi_active_q, fi_active_d;
  logic [7:0]    idx_cnt_q, idx_cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          abort_req_q, abort_req_d;
  logic          intrq_q, intrq_d;
  logic          interrupt_q, interrupt_d;
  logic          armed_q, armed_d;
  logic          prev_rdy_q, prev_rdy_d;
  logic          prev_idx_q, prev_idx_d;

  drv_sig_t cur_s;
  logic     complete;
  logic [3:0] comp_cond;

  assign cur_s = sync_s[drv_q];

  // Previous samples follow the next-cycle drive, so a newly latched drive
  // starts with history equal to its current level and cannot false-fire.
  assign prev_rdy_d = sync_s[drv_d].readyn;
  assign prev_idx_d = sync_s[drv_d].indexn;

  always_comb begin
    state_d     = state_q;
    cond_d      = cond_q;
    drv_d       = drv_q;
    fi_active_d = fi_active_q;
    idx_cnt_d   = idx_cnt_q;
    tmr_d       = tmr_q;
    abort_req_d = abort_req_q;
    intrq_d     = intrq_q;
    interrupt_d = 1'b0;
    complete    = 1'b0;
    comp_cond   = cond_q;

    if (INTRQ_ACK) intrq_d = 1'b0;

    if (command_start) begin
      intrq_d = 1'b0;
      if (command[7:4] == CMD_FORCE_INT) begin
        cond_d      = command[3:0];
        drv_d       = drive_sel;
        fi_active_d = 1'b1;
        interrupt_d = 1'b1;
        idx_cnt_d   = 8'd0;
        comp_cond   = command[3:0];
        if (busy_in) begin
          abort_req_d = 1'b1;
          tmr_d       = TMR_LOAD;
          state_d     = ST_ABORT_WAIT;
        end else begin
          abort_req_d = 1'b0;
          complete    = 1'b1;
        end
      end else begin
        state_d     = ST_IDLE;
        fi_active_d = 1'b0;
        abort_req_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_ABORT_WAIT: begin
          if (abort_done || tmr_q == '0) begin
            abort_req_d = 1'b0;
            complete    = 1'b1;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        ST_ARMED: begin
          if (cond_q[FI_RDY_RISE] && prev_rdy_q && !cur_s.readyn) intrq_d = 1'b1;
          if (cond_q[FI_RDY_FALL] && !prev_rdy_q && cur_s.readyn) intrq_d = 1'b1;
          if (cond_q[FI_INDEX] && prev_idx_q && !cur_s.indexn) begin
            if (idx_cnt_q == IDX_LAST) begin
              intrq_d   = 1'b1;
              idx_cnt_d = 8'd0;
            end else begin
              idx_cnt_d = idx_cnt_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end

    if (complete) begin
      if (comp_cond[FI_IMM]) intrq_d = 1'b1;
      state_d = (comp_cond[2:0] != 3'b000) ? ST_ARMED : ST_IDLE;
    end

    armed_d = (state_d == ST_ARMED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cond_q      <= 4'h0;
      drv_q       <= '0;
      fi_active_q <= 1'b0;
      idx_cnt_q   <= 8'd0;
      tmr_q       <= '0;
      abort_req_q <= 1'b0;
      intrq_q     <= 1'b0;
      interrupt_q <= 1'b0;
      armed_q     <= 1'b0;
      prev_rdy_q  <= 1'b1;
      prev_idx_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cond_q      <= cond_d;
      drv_q       <= drv_d;
      fi_active_q <= fi_active_d;
      idx_cnt_q   <= idx_cnt_d;
      tmr_q       <= tmr_d;
      abort_req_q <= abort_req_d;
      intrq_q     <= intrq_d;
      interrupt_q <= interrupt_d;
      armed_q     <= armed_d;
      prev_rdy_q  <= prev_rdy_d;
      prev_idx_q  <= prev_idx_d;
    end
  end

  assign abort_req = abort_req_q;
  assign INTRQ     = intrq_q;
  assign interrupt = interrupt_q;
  assign armed     = armed_q;
  assign status    = fi_active_q ? type1_status(cur_s, HLD) : 8'h00;

endmodule

// File: tb/tb_wd279x_force_intr_ctrl.sv
// Bench for wd279x_force_intr_ctrl: directed scenarios then random traffic,
// every cycle compared against an input-history reference model.
module tb_wd279x_force_intr_ctrl;

  localparam int DRIVES = 4;
  localparam int S      = 2;
  localparam int IDIV   = 3;
  localparam int ATO    = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, command_start, busy_in, abort_done, HLD, INTRQ_ACK;
  logic [7:0]  command;
  logic [1:0]  drive_sel;
  logic [3:0]  INDEXn, READYn, WPROTn, TRK00n;
  logic        abort_req, INTRQ, interrupt, armed;
  logic [7:0]  status;

  wd279x_force_intr_ctrl #(
    .DRIVES(DRIVES), .SYNC_STAGES(S), .INDEX_DIV(IDIV), .ABORT_TIMEOUT(ATO)
  ) dut (
    .clk(clk), .reset(reset), .command_start(command_start), .command(command),
    .drive_sel(drive_sel), .busy_in(busy_in), .abort_req(abort_req),
    .abort_done(abort_done), .INDEXn(INDEXn), .READYn(READYn), .WPROTn(WPROTn),
    .TRK00n(TRK00n), .HLD(HLD), .INTRQ(INTRQ), .INTRQ_ACK(INTRQ_ACK),
    .interrupt(interrupt), .armed(armed), .status(status)
  );

  int n_total = 0;
  int n_pass  = 0;

  // hX[d][k]: raw level of drive d sampled k clock edges ago (k=0 newest).
  bit hr [DRIVES][S+2];
  bit hi [DRIVES][S+2];
  bit hw [DRIVES][S+2];
  bit ht [DRIVES][S+2];

  bit       m_intrq, m_intr, m_abort, m_armed, m_wait, m_fi;
  bit [3:0] m_cond;
  int       m_drv, m_idx, m_wait_n;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] m_status();
    if (!m_fi) return 8'h00;
    return {hr[m_drv][S-1], ~hw[m_drv][S-1], HLD, 2'b00,
            ~ht[m_drv][S-1], ~hi[m_drv][S-1], 1'b0};
  endfunction

  task automatic finish_fi(output bit f);
    m_armed = (m_cond[2:0] != 3'b000);
    f       = m_cond[3];
  endtask

  task automatic model_edge();
    bit fire, f, cur_r, prev_r, cur_i, prev_i;
    for (int d = 0; d < DRIVES; d++) begin
      for (int k = S + 1; k > 0; k--) begin
        hr[d][k] = hr[d][k-1]; hi[d][k] = hi[d][k-1];
        hw[d][k] = hw[d][k-1]; ht[d][k] = ht[d][k-1];
      end
      hr[d][0] = reset ? 1'b1 : READYn[d];
      hi[d][0] = reset ? 1'b1 : INDEXn[d];
      hw[d][0] = reset ? 1'b1 : WPROTn[d];
      ht[d][0] = reset ? 1'b1 : TRK00n[d];
    end
    if (reset) begin
      m_intrq = 0; m_intr = 0; m_abort = 0; m_armed = 0; m_wait = 0; m_fi = 0;
      m_cond = 0; m_drv = 0; m_idx = 0; m_wait_n = 0;
    end else begin
      cur_r  = hr[m_drv][S]; prev_r = hr[m_drv][S+1];
      cur_i  = hi[m_drv][S]; prev_i = hi[m_drv][S+1];
      fire   = 0;
      m_intr = 0;
      if (command_start && command[7:4] == 4'hD) begin
        m_cond = command[3:0]; m_drv = int'(drive_sel); m_fi = 1; m_intr = 1; m_idx = 0;
        if (busy_in) begin
          m_wait = 1; m_armed = 0; m_abort = 1; m_wait_n = 0;
        end else begin
          m_wait = 0; m_abort = 0;
          finish_fi(fire);
        end
      end else if (command_start) begin
        m_wait = 0; m_armed = 0; m_fi = 0; m_abort = 0;
      end else if (m_wait) begin
        m_wait_n++;
        if (abort_done || m_wait_n == ATO) begin
          m_wait = 0; m_abort = 0;
          finish_fi(fire);
        end
      end else if (m_armed) begin
        if (m_cond[0] && prev_r && !cur_r) fire = 1;
        if (m_cond[1] && !prev_r && cur_r) fire = 1;
        if (m_cond[2] && prev_i && !cur_i) begin
          m_idx++;
          if (m_idx == IDIV) begin
            fire  = 1;
            m_idx = 0;
          end
        end
      end
      f = command_start || INTRQ_ACK;
      if (fire)   m_intrq = 1;
      else if (f) m_intrq = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("intrq",     8'(INTRQ),     8'(m_intrq));
    chk("interrupt", 8'(interrupt), 8'(m_intr));
    chk("abort_req", 8'(abort_req), 8'(m_abort));
    chk("armed",     8'(armed),     8'(m_armed));
    chk("status",    status,        m_status());
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic cmd(input logic [7:0] c, input logic [1:0] d, input logic busy);
    command = c; drive_sel = d; busy_in = busy; command_start = 1'b1;
    tick();
    command_start = 1'b0; busy_in = 1'b0;
  endtask

  task automatic ack();
    INTRQ_ACK = 1'b1;
    tick();
    INTRQ_ACK = 1'b0;
  endtask

  int cnt;

  initial begin
    for (int d = 0; d < DRIVES; d++)
      for (int k = 0; k < S + 2; k++) begin
        hr[d][k] = 1; hi[d][k] = 1; hw[d][k] = 1; ht[d][k] = 1;
      end
    reset = 1; command_start = 0; command = 8'h00; drive_sel = 2'd0; busy_in = 0;
    abort_done = 0; HLD = 0; INTRQ_ACK = 0;
    INDEXn = '1; READYn = '1; WPROTn = '1; TRK00n = '1;
    idle(3);
    reset = 0;
    idle(2);
    chk("rst_intrq", 8'(INTRQ), 8'd0);
    chk("rst_status", status, 8'h00);

    // immediate interrupt, not busy
    cmd(8'hD8, 2'd0, 1'b0);
    chk("t1_intr",  8'(interrupt), 8'd1);
    chk("t1_intrq", 8'(INTRQ),     8'd1);
    chk("t1_armed", 8'(armed),     8'd0);
    tick();
    chk("t1_pulse_end", 8'(interrupt), 8'd0);
    ack();
    chk("t1_ack", 8'(INTRQ), 8'd0);

    // abort handshake: done after 5 cycles
    cmd(8'hD8, 2'd0, 1'b1);
    chk("t2_abort_set", 8'(abort_req), 8'd1);
    chk("t2_no_intrq",  8'(INTRQ),     8'd0);
    idle(4);
    abort_done = 1'b1;
    tick();
    abort_done = 1'b0;
    chk("t2_abort_drop", 8'(abort_req), 8'd0);
    chk("t2_intrq",      8'(INTRQ),     8'd1);
    ack();

    // abort timeout
    cmd(8'hD8, 2'd0, 1'b1);
    cnt = 0;
    for (int i = 0; i < ATO + 5; i++) begin
      if (abort_req) cnt++;
      tick();
    end
    chk("t2_timeout_len", 8'(cnt), 8'(ATO));
    chk("t2_timeout_intrq", 8'(INTRQ), 8'd1);
    ack();

    // READY rise on drive 2; latency and drive isolation
    cmd(8'hD1, 2'd2, 1'b0);
    chk("t3_armed", 8'(armed), 8'd1);
    READYn[2] = 1'b0;
    tick(); chk("t3_lat1", 8'(INTRQ), 8'd0);
    tick(); chk("t3_lat2", 8'(INTRQ), 8'd0);
    tick(); chk("t3_lat3", 8'(INTRQ), 8'd1);
    ack();
    READYn[1] = 1'b0; idle(4); chk("t3_other_fall", 8'(INTRQ), 8'd0);
    READYn[1] = 1'b1; idle(4); chk("t3_other_rise", 8'(INTRQ), 8'd0);
    READYn[2] = 1'b1; idle(4); chk("t3_wrong_dir",  8'(INTRQ), 8'd0);

    // index divider: fires on every third pulse
    cmd(8'hD4, 2'd0, 1'b0);
    for (int p = 1; p <= 9; p++) begin
      INDEXn[0] = 1'b0; idle(2);
      INDEXn[0] = 1'b1; idle(2);
      chk($sformatf("t4_pulse%0d", p), 8'(INTRQ), 8'((p % 3) == 0));
      ack();
    end

    // status view, READY fall condition, non-FI cancel
    READYn[3] = 1'b0; WPROTn[3] = 1'b0; TRK00n[3] = 1'b0; HLD = 1'b1;
    idle(4);
    cmd(8'hD2, 2'd3, 1'b0);
    idle(3);
    chk("t5_status", status, 8'h64);
    READYn[3] = 1'b1; idle(3);
    chk("t5_fire", 8'(INTRQ), 8'd1);
    cmd(8'h80, 2'd0, 1'b0);
    chk("t5_clr_intrq",  8'(INTRQ),  8'd0);
    chk("t5_clr_armed",  8'(armed),  8'd0);
    chk("t5_clr_status", status,     8'h00);
    READYn[3] = 1'b0; idle(4);
    READYn[3] = 1'b1; idle(4);
    chk("t5_no_fire", 8'(INTRQ), 8'd0);

    // ACK coinciding with a set condition
    cmd(8'hD9, 2'd1, 1'b0);
    chk("t6_imm", 8'(INTRQ), 8'd1);
    READYn[1] = 1'b0;
    idle(2);
    ack();
    chk("t6_set_wins", 8'(INTRQ), 8'd1);
    ack();
    chk("t6_ack_clears", 8'(INTRQ), 8'd0);

    // reset during ABORT_WAIT
    cmd(8'hD8, 2'd0, 1'b1);
    idle(3);
    chk("t6_wait_abort", 8'(abort_req), 8'd1);
    reset = 1'b1;
    tick();
    chk("t6_rst_abort",  8'(abort_req), 8'd0);
    chk("t6_rst_intrq",  8'(INTRQ),     8'd0);
    chk("t6_rst_intr",   8'(interrupt), 8'd0);
    chk("t6_rst_armed",  8'(armed),     8'd0);
    chk("t6_rst_status", status,        8'h00);
    reset = 1'b0;
    idle(2);

    // random traffic against the model
    for (int c = 0; c < 800; c++) begin
      for (int d = 0; d < DRIVES; d++) begin
        if ($urandom_range(5) == 0)  READYn[d] = ~READYn[d];
        if ($urandom_range(4) == 0)  INDEXn[d] = ~INDEXn[d];
        if ($urandom_range(39) == 0) WPROTn[d] = ~WPROTn[d];
        if ($urandom_range(39) == 0) TRK00n[d] = ~TRK00n[d];
      end
      if ($urandom_range(15) == 0) HLD = ~HLD;
      INTRQ_ACK  = ($urandom_range(9) == 0);
      abort_done = ($urandom_range(7) == 0);
      if ($urandom_range(14) == 0) begin
        command = 8'($urandom_range(255));
        if ($urandom_range(2) != 0)       command[7:4] = 4'hD;
        else if (command[7:4] == 4'hD)    command[7:4] = 4'h8;
        drive_sel     = 2'($urandom_range(3));
        busy_in       = ($urandom_range(1) == 1);
        command_start = 1'b1;
      end else begin
        command_start = 1'b0;
        busy_in       = 1'b0;
      end
      tick();
    end
    command_start = 1'b0; INTRQ_ACK = 1'b0; abort_done = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
